com_loader: RTL and testbench
=============================

Name: com_loader

Overview:
- Upstream stage of the com/processor memory-port selector.
- Takes the byte stream from the UART receiver and produces the com-side memory-port signals: ComEN, WriteFromCom, AddFromCom and DatFromCom.
- Loads a program/data image into memory while the processor is held off the memory port.
- Frame format: 16-bit word count N (low byte first), then N 16-bit words (low byte first), then an optional checksum byte.

Parameters:
- BASE_ADDR, 16'h0000, address of the first word written.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes while loading before the load aborts; range 1..2^24-1.

Ports:
- Clk  input  1  system clock, rising edge.
- ResetN  input  1  asynchronous, active-low reset.
- Start  input  1  load request; sampled only in IDLE.
- RxData  input  8  received byte; valid only when RxValid=1.
- RxValid  input  1  one-cycle strobe per received byte.
- ComEN  output  1  com interface owns the memory port.
- WriteFromCom  output  1  one-cycle memory write strobe.
- AddFromCom  output  16  write address.
- DatFromCom  output  16  write data.
- Done  output  1  one-cycle pulse at end of a load, successful or aborted.
- Error  output  1  sticky error flag; cleared by the next accepted Start.

Behaviour:
- Reset values (ResetN=0, takes effect immediately): state IDLE, ComEN=0, WriteFromCom=0, AddFromCom=BASE_ADDR, DatFromCom=0, Done=0, Error=0, word counter=0, timeout counter=0.
- Reset mid-load drops the partial frame. No further writes occur; writes already completed stand.
- All outputs are registered.
- States: IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, WRITE, CHK (feature only), DONE.
- IDLE:
  - Start=1 -> LEN_LO; clear Error; AddFromCom<=BASE_ADDR.
  - ComEN is 1 from the cycle after Start until the cycle after DONE.
  - Start in any other state is ignored.
- LEN_LO / LEN_HI: on RxValid, capture count[7:0] / count[15:8].
  - In LEN_HI, if the 16-bit count is 0 -> CHK (feature) or DONE; else -> DAT_LO.
- DAT_LO: on RxValid, latch the low byte into a holding register -> DAT_HI.
- DAT_HI: on RxValid:
  - DatFromCom <= {RxData, low byte}.
  - Decrement the remaining count.
  - -> WRITE.
- WRITE (exactly one cycle):
  - WriteFromCom=1, with AddFromCom/DatFromCom stable for that cycle.
  - Next cycle: AddFromCom increments by 1, wrapping 16'hFFFF -> 16'h0000.
  - If remaining count = 0 -> CHK (feature) or DONE; else -> DAT_LO.
- Latency: the write strobe is asserted the cycle after the high-byte RxValid.
- DONE (one cycle): Done=1, ComEN still 1 -> IDLE; ComEN=0 from the next cycle.
- Overrun: RxValid in WRITE or DONE drops the byte and sets Error=1; the load continues.
- RxValid in IDLE is ignored and does not set Error.
- Timeout:
  - In LEN_LO..CHK the timeout counter counts cycles without RxValid and resets on every RxValid.
  - On reaching TIMEOUT_CYCLES: Error=1 -> DONE.
  - No write is issued for a half-received word.
- DatFromCom and AddFromCom hold their last values between writes and after the load.
- Maximum frame is 65535 words. Address wrap is allowed and is not an error.

Optional Feature:
- Macro: COM_LOADER_CHECKSUM_EN.
- Defined:
  - Track an 8-bit running sum (mod 256) of every data byte, excluding the length bytes.
  - After the last word (or after LEN_HI with N=0), enter CHK and wait for one byte.
  - On its RxValid: a mismatch with the sum sets Error=1; -> DONE.
  - The timeout applies in CHK.
- Not defined: the CHK state and sum register are absent; the last WRITE (or LEN_HI with N=0) goes directly to DONE.

Test Plan:
- Reset values: with ResetN=0, then released -> ComEN=0, WriteFromCom=0, AddFromCom=BASE_ADDR, Done=0, Error=0; mid-load ResetN low drops the frame and no later writes occur.
- Basic two-word load: Start; bytes 02 00 34 12 CD AB (feature off) -> writes (0000,1234) then (0001,ABCD), each a one-cycle strobe one cycle after the high byte; Done pulse; ComEN falls the cycle after Done; Error=0.
- Zero-length frame: Start; bytes 00 00 -> no WriteFromCom; Done pulse in the next state cycle; Error=0.
- Address wrap: BASE_ADDR=16'hFFFF, 2 words -> addresses FFFF then 0000.
- Timeout and overrun:
  - TIMEOUT_CYCLES=50; send 01 00 78 then stall 50 cycles -> Error=1, Done, no write.
  - Separately, an RxValid injected in the WRITE cycle -> Error=1 and the byte is dropped.
- Checksum (feature on):
  - Frame 01 00 34 12 46 -> write (0000,1234), Error=0.
  - Same frame with checksum 47 -> write still occurs, Error=1, Done pulses.
  - Next Start clears Error.

Source files
------------

// File: rtl/com_loader.sv
`default_nettype none
// ============================================================================
// Module   : com_loader
// Purpose  : Turns the UART byte stream into com-side memory writes.
//            Frame: N (16b, LE), N words (LE), optional checksum byte when
//            COM_LOADER_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module com_loader #(
  parameter logic [15:0] BASE_ADDR      = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        Start,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        ComEN,
  output logic        WriteFromCom,
  output logic [15:0] AddFromCom,
  output logic [15:0] DatFromCom,
  output logic        Done,
  output logic        Error
);

  localparam logic [23:0] c_timeout = 24'(TIMEOUT_CYCLES);

`ifdef COM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LEN_LO = 3'd1, S_LEN_HI = 3'd2, S_DAT_LO = 3'd3,
    S_DAT_HI = 3'd4, S_WRITE = 3'd5, S_CHK = 3'd6, S_DONE = 3'd7
  } state_t;
  localparam state_t c_end_state = S_CHK;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LEN_LO = 3'd1, S_LEN_HI = 3'd2, S_DAT_LO = 3'd3,
    S_DAT_HI = 3'd4, S_WRITE = 3'd5, S_DONE = 3'd7
  } state_t;
  localparam state_t c_end_state = S_DONE;
`endif

  state_t      r_state, w_state;
  logic [15:0] r_cnt, w_cnt;
  logic [7:0]  r_lo, w_lo;
  logic [23:0] r_tmr, w_tmr;
  logic [15:0] r_addr, w_addr;
  logic [15:0] r_dat, w_dat;
  logic        r_comen, w_comen;
  logic        r_wr, w_wr;
  logic        r_done, w_done;
  logic        r_err, w_err;
  logic        w_active;
  logic        w_timeout;
`ifdef COM_LOADER_CHECKSUM_EN
  logic [7:0]  r_sum, w_sum;
`endif

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_lo      = r_lo;
    w_addr    = r_addr;
    w_dat     = r_dat;
    w_err     = r_err;
    w_tmr     = 24'd0;
    w_timeout = 1'b0;
`ifdef COM_LOADER_CHECKSUM_EN
    w_sum     = r_sum;
`endif
    // Idle-gap timer runs only while a frame is in flight.
    w_active = (r_state != S_IDLE) && (r_state != S_DONE);
    if (w_active && !RxValid) begin
      w_tmr     = r_tmr + 24'd1;
      w_timeout = (w_tmr == c_timeout);
    end

    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state = S_LEN_LO;
          w_err   = 1'b0;
          w_addr  = BASE_ADDR;
          w_cnt   = 16'd0;
`ifdef COM_LOADER_CHECKSUM_EN
          w_sum   = 8'd0;
`endif
        end
      end
      S_LEN_LO: begin
        if (RxValid) begin
          w_cnt[7:0] = RxData;
          w_state    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (RxValid) begin
          w_cnt[15:8] = RxData;
          w_state     = ({RxData, r_cnt[7:0]} == 16'd0) ? c_end_state : S_DAT_LO;
        end
      end
      S_DAT_LO: begin
        if (RxValid) begin
          w_lo    = RxData;
          w_state = S_DAT_HI;
`ifdef COM_LOADER_CHECKSUM_EN
          w_sum   = r_sum + RxData;
`endif
        end
      end
      S_DAT_HI: begin
        if (RxValid) begin
          w_dat   = {RxData, r_lo};
          w_cnt   = r_cnt - 16'd1;
          w_state = S_WRITE;
`ifdef COM_LOADER_CHECKSUM_EN
          w_sum   = r_sum + RxData;
`endif
        end
      end
      S_WRITE: begin
        // Bytes arriving while the strobe is out are dropped as overrun.
        w_addr  = r_addr + 16'd1;
        w_state = (r_cnt == 16'd0) ? c_end_state : S_DAT_LO;
        if (RxValid) w_err = 1'b1;
      end
`ifdef COM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (RxValid) begin
          if (RxData != r_sum) w_err = 1'b1;
          w_state = S_DONE;
        end
      end
`endif
      S_DONE: begin
        w_state = S_IDLE;
        if (RxValid) w_err = 1'b1;
      end
      default: w_state = S_IDLE;
    endcase

    if (w_timeout) begin
      w_err   = 1'b1;
      w_state = S_DONE;
    end

    w_comen = (w_state != S_IDLE);
    w_wr    = (w_state == S_WRITE);
    w_done  = (w_state == S_DONE);
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_lo    <= 8'd0;
      r_tmr   <= 24'd0;
      r_addr  <= BASE_ADDR;
      r_dat   <= 16'd0;
      r_comen <= 1'b0;
      r_wr    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef COM_LOADER_CHECKSUM_EN
      r_sum   <= 8'd0;
`endif
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_lo    <= w_lo;
      r_tmr   <= w_tmr;
      r_addr  <= w_addr;
      r_dat   <= w_dat;
      r_comen <= w_comen;
      r_wr    <= w_wr;
      r_done  <= w_done;
      r_err   <= w_err;
`ifdef COM_LOADER_CHECKSUM_EN
      r_sum   <= w_sum;
`endif
    end
  end

  assign ComEN        = r_comen;
  assign WriteFromCom = r_wr;
  assign AddFromCom   = r_addr;
  assign DatFromCom   = r_dat;
  assign Done         = r_done;
  assign Error        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_com_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_com_loader
// Purpose  : Scoreboard bench for com_loader (two instances: base 0000 and
//            base FFFF, both with a 50-cycle byte timeout).
// Revision : 1.0 - initial release
// ============================================================================
module tb_com_loader;

  logic        Clk = 1'b0;
  logic        ResetN = 1'b0;
  logic        Start0 = 1'b0;
  logic        Start1 = 1'b0;
  logic [7:0]  RxData = 8'h00;
  logic        RxValid = 1'b0;

  logic        w_comen0, w_wr0, w_done0, w_err0;
  logic [15:0] w_addr0, w_dat0;
  logic        w_comen1, w_wr1, w_done1, w_err1;
  logic [15:0] w_addr1, w_dat1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    int unsigned c;
  } wr_t;

  wr_t         sb0[$];
  wr_t         sb1[$];
  wr_t         e0, e1;
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

`ifdef COM_LOADER_CHECKSUM_EN
  localparam int c_done_lag = 0;
`else
  localparam int c_done_lag = 1;
`endif

  com_loader #(.BASE_ADDR(16'h0000), .TIMEOUT_CYCLES(50)) dut0 (
    .Clk(Clk), .ResetN(ResetN), .Start(Start0), .RxData(RxData), .RxValid(RxValid),
    .ComEN(w_comen0), .WriteFromCom(w_wr0), .AddFromCom(w_addr0), .DatFromCom(w_dat0),
    .Done(w_done0), .Error(w_err0)
  );

  com_loader #(.BASE_ADDR(16'hFFFF), .TIMEOUT_CYCLES(50)) dut1 (
    .Clk(Clk), .ResetN(ResetN), .Start(Start1), .RxData(RxData), .RxValid(RxValid),
    .ComEN(w_comen1), .WriteFromCom(w_wr1), .AddFromCom(w_addr1), .DatFromCom(w_dat1),
    .Done(w_done1), .Error(w_err1)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Every strobe cycle must match the next expected write, including its cycle.
  always @(negedge Clk) begin
    if (w_wr0 === 1'b1) begin
      n_chk++;
      if (sb0.size() == 0) begin
        n_fail++;
        $display("FAIL wr0_unexpected: got addr=%h dat=%h cyc=%0d, expected no write", w_addr0, w_dat0, cyc);
      end else begin
        e0 = sb0.pop_front();
        if (w_addr0 !== e0.a || w_dat0 !== e0.d || cyc !== e0.c) begin
          n_fail++;
          $display("FAIL wr0_data: got addr=%h dat=%h cyc=%0d, expected addr=%h dat=%h cyc=%0d",
                   w_addr0, w_dat0, cyc, e0.a, e0.d, e0.c);
        end
      end
    end
    if (w_wr1 === 1'b1) begin
      n_chk++;
      if (sb1.size() == 0) begin
        n_fail++;
        $display("FAIL wr1_unexpected: got addr=%h dat=%h cyc=%0d, expected no write", w_addr1, w_dat1, cyc);
      end else begin
        e1 = sb1.pop_front();
        if (w_addr1 !== e1.a || w_dat1 !== e1.d || cyc !== e1.c) begin
          n_fail++;
          $display("FAIL wr1_data: got addr=%h dat=%h cyc=%0d, expected addr=%h dat=%h cyc=%0d",
                   w_addr1, w_dat1, cyc, e1.a, e1.d, e1.c);
        end
      end
    end
  end

  task automatic do_start(input int sel);
    @(negedge Clk);
    if (sel == 0) Start0 = 1'b1; else Start1 = 1'b1;
    @(negedge Clk);
    Start0 = 1'b0;
    Start1 = 1'b0;
  endtask

  // One-cycle RxValid strobe; an expected write lands one cycle after the byte.
  task automatic send_byte(input logic [7:0] b, input int sel, input bit exp,
                           input logic [15:0] a, input logic [15:0] d);
    wr_t e;
    @(negedge Clk);
    RxData  = b;
    RxValid = 1'b1;
    if (exp) begin
      e.a = a;
      e.d = d;
      e.c = cyc + 1;
      if (sel == 0) sb0.push_back(e); else sb1.push_back(e);
    end
    @(negedge Clk);
    RxValid = 1'b0;
  endtask

  task automatic send_frame(input int sel, input logic [15:0] base, input int nw,
                            input logic [15:0] w0, input logic [15:0] w1);
    logic [15:0] w;
    logic [15:0] n;
`ifdef COM_LOADER_CHECKSUM_EN
    logic [7:0]  sum;
    sum = 8'h00;
`endif
    n = 16'(nw);
    send_byte(n[7:0], sel, 1'b0, 16'h0, 16'h0);
    send_byte(n[15:8], sel, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < nw; i++) begin
      w = (i == 0) ? w0 : w1;
      send_byte(w[7:0], sel, 1'b0, 16'h0, 16'h0);
      send_byte(w[15:8], sel, 1'b1, base + 16'(i), w);
`ifdef COM_LOADER_CHECKSUM_EN
      sum = sum + w[7:0] + w[15:8];
`endif
    end
`ifdef COM_LOADER_CHECKSUM_EN
    send_byte(sum, sel, 1'b0, 16'h0, 16'h0);
`endif
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    repeat (3) @(negedge Clk);
    ResetN = 1'b1;
    @(negedge Clk);
    n_chk++; if (w_comen0 !== 1'b0) begin n_fail++; $display("FAIL reset_comen: got %b expected 0", w_comen0); end
    n_chk++; if (w_wr0 !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b expected 0", w_wr0); end
    n_chk++; if (w_addr0 !== 16'h0000) begin n_fail++; $display("FAIL reset_addr0: got %h expected 0000", w_addr0); end
    n_chk++; if (w_addr1 !== 16'hFFFF) begin n_fail++; $display("FAIL reset_addr1: got %h expected ffff", w_addr1); end
    n_chk++; if (w_dat0 !== 16'h0000) begin n_fail++; $display("FAIL reset_dat: got %h expected 0000", w_dat0); end
    n_chk++; if (w_done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", w_done0); end
    n_chk++; if (w_err0 !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", w_err0); end
  endtask

  task automatic test_basic();
    do_start(0);
    n_chk++; if (w_comen0 !== 1'b1) begin n_fail++; $display("FAIL basic_comen_after_start: got %b expected 1", w_comen0); end
    send_frame(0, 16'h0000, 2, 16'h1234, 16'hABCD);
    repeat (c_done_lag) @(negedge Clk);
    n_chk++; if (w_done0 !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", w_done0); end
    n_chk++; if (w_comen0 !== 1'b1) begin n_fail++; $display("FAIL basic_comen_in_done: got %b expected 1", w_comen0); end
    n_chk++; if (w_err0 !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %b expected 0", w_err0); end
    @(negedge Clk);
    n_chk++; if (w_done0 !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", w_done0); end
    n_chk++; if (w_comen0 !== 1'b0) begin n_fail++; $display("FAIL basic_comen_fall: got %b expected 0", w_comen0); end
    n_chk++; if (w_addr0 !== 16'h0002 || w_dat0 !== 16'hABCD) begin
      n_fail++; $display("FAIL basic_hold: got addr=%h dat=%h expected addr=0002 dat=abcd", w_addr0, w_dat0);
    end
    n_chk++; if (sb0.size() !== 0) begin n_fail++; $display("FAIL basic_missing_writes: got %0d pending expected 0", sb0.size()); end
  endtask

  task automatic test_zero_length();
    do_start(0);
    send_frame(0, 16'h0000, 0, 16'h0000, 16'h0000);
    n_chk++; if (w_done0 !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b expected 1", w_done0); end
    n_chk++; if (w_err0 !== 1'b0) begin n_fail++; $display("FAIL zero_error: got %b expected 0", w_err0); end
    n_chk++; if (w_addr0 !== 16'h0000) begin n_fail++; $display("FAIL zero_addr: got %h expected 0000", w_addr0); end
    @(negedge Clk);
    n_chk++; if (w_done0 !== 1'b0 || w_comen0 !== 1'b0) begin
      n_fail++; $display("FAIL zero_after: got done=%b comen=%b expected 0 0", w_done0, w_comen0);
    end
  endtask

  task automatic test_addr_wrap();
    do_start(1);
    send_frame(1, 16'hFFFF, 2, 16'h0001, 16'h0002);
    repeat (c_done_lag) @(negedge Clk);
    n_chk++; if (w_done1 !== 1'b1) begin n_fail++; $display("FAIL wrap_done: got %b expected 1", w_done1); end
    n_chk++; if (w_err1 !== 1'b0) begin n_fail++; $display("FAIL wrap_error: got %b expected 0", w_err1); end
    @(negedge Clk);
    n_chk++; if (w_addr1 !== 16'h0001) begin n_fail++; $display("FAIL wrap_addr_after: got %h expected 0001", w_addr1); end
    n_chk++; if (sb1.size() !== 0) begin n_fail++; $display("FAIL wrap_missing_writes: got %0d pending expected 0", sb1.size()); end
    n_chk++; if (w_err0 !== 1'b0 || w_comen0 !== 1'b0) begin
      n_fail++; $display("FAIL idle_rx_ignored: got err=%b comen=%b expected 0 0", w_err0, w_comen0);
    end
  endtask

  task automatic test_timeout();
    int k;
    do_start(0);
    send_byte(8'h01, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h00, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h78, 0, 1'b0, 16'h0, 16'h0);
    k = 0;
    while (w_done0 !== 1'b1 && k < 60) begin
      @(negedge Clk);
      k++;
    end
    n_chk++; if (k !== 50) begin n_fail++; $display("FAIL timeout_latency: got %0d idle cycles expected 50", k); end
    n_chk++; if (w_err0 !== 1'b1) begin n_fail++; $display("FAIL timeout_error: got %b expected 1", w_err0); end
    @(negedge Clk);
    n_chk++; if (w_err0 !== 1'b1 || w_comen0 !== 1'b0) begin
      n_fail++; $display("FAIL timeout_after: got err=%b comen=%b expected 1 0", w_err0, w_comen0);
    end
  endtask

  task automatic test_overrun();
    do_start(0);
    n_chk++; if (w_err0 !== 1'b0) begin n_fail++; $display("FAIL start_clears_error: got %b expected 0", w_err0); end
    send_byte(8'h02, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h00, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h11, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h22, 0, 1'b1, 16'h0000, 16'h2211);
    n_chk++; if (w_wr0 !== 1'b1) begin n_fail++; $display("FAIL overrun_in_write: got strobe %b expected 1", w_wr0); end
    RxData  = 8'hEE;
    RxValid = 1'b1;
    @(negedge Clk);
    RxValid = 1'b0;
    n_chk++; if (w_err0 !== 1'b1) begin n_fail++; $display("FAIL overrun_error: got %b expected 1", w_err0); end
    send_byte(8'h33, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h44, 0, 1'b1, 16'h0001, 16'h4433);
`ifdef COM_LOADER_CHECKSUM_EN
    send_byte(8'hAA, 0, 1'b0, 16'h0, 16'h0);
`endif
    repeat (c_done_lag) @(negedge Clk);
    n_chk++; if (w_done0 !== 1'b1 || w_err0 !== 1'b1) begin
      n_fail++; $display("FAIL overrun_done: got done=%b err=%b expected 1 1", w_done0, w_err0);
    end
    @(negedge Clk);
    n_chk++; if (sb0.size() !== 0) begin n_fail++; $display("FAIL overrun_missing_writes: got %0d pending expected 0", sb0.size()); end
  endtask

  task automatic test_midload_reset();
    do_start(0);
    send_byte(8'h02, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h00, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h55, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h66, 0, 1'b1, 16'h0000, 16'h6655);
    send_byte(8'h77, 0, 1'b0, 16'h0, 16'h0);
    @(negedge Clk);
    #2 ResetN = 1'b0;
    #1;
    n_chk++; if (w_comen0 !== 1'b0 || w_addr0 !== 16'h0000 || w_dat0 !== 16'h0000) begin
      n_fail++; $display("FAIL async_reset: got comen=%b addr=%h dat=%h expected 0 0000 0000", w_comen0, w_addr0, w_dat0);
    end
    @(negedge Clk);
    ResetN = 1'b1;
    send_byte(8'h88, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h99, 0, 1'b0, 16'h0, 16'h0);
    repeat (4) @(negedge Clk);
    n_chk++; if (w_comen0 !== 1'b0 || w_err0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_drops_frame: got comen=%b err=%b expected 0 0", w_comen0, w_err0);
    end
    n_chk++; if (sb0.size() !== 0) begin n_fail++; $display("FAIL reset_pending_writes: got %0d pending expected 0", sb0.size()); end
  endtask

`ifdef COM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_start(0);
    send_frame(0, 16'h0000, 1, 16'h1234, 16'h0000);
    n_chk++; if (w_done0 !== 1'b1 || w_err0 !== 1'b0) begin
      n_fail++; $display("FAIL chk_good: got done=%b err=%b expected 1 0", w_done0, w_err0);
    end
    do_start(0);
    send_byte(8'h01, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h00, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h34, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h12, 0, 1'b1, 16'h0000, 16'h1234);
    send_byte(8'h47, 0, 1'b0, 16'h0, 16'h0);
    n_chk++; if (w_done0 !== 1'b1 || w_err0 !== 1'b1) begin
      n_fail++; $display("FAIL chk_bad: got done=%b err=%b expected 1 1", w_done0, w_err0);
    end
    do_start(0);
    n_chk++; if (w_err0 !== 1'b0) begin n_fail++; $display("FAIL chk_start_clears: got %b expected 0", w_err0); end
    send_frame(0, 16'h0000, 0, 16'h0000, 16'h0000);
    n_chk++; if (w_done0 !== 1'b1) begin n_fail++; $display("FAIL chk_zero_done: got %b expected 1", w_done0); end
    @(negedge Clk);
    n_chk++; if (sb0.size() !== 0) begin n_fail++; $display("FAIL chk_missing_writes: got %0d pending expected 0", sb0.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_addr_wrap();
    test_timeout();
    test_overrun();
    test_midload_reset();
`ifdef COM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test to complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
